// File: rtl/fifo_reader_if.sv
// Purpose: groups the FIFO read-side signals and the outgoing valid/ready stream of fifo_reader.
// Ports  : o_fifo_rd / i_fifo_empty_n / i_fifo_data (FIFO side), o_valid / i_ready / o_data (stream side).
// Modports: master = the reader itself, slave = the FIFO plus downstream consumer environment.
interface fifo_reader_if #(
  parameter int B = 8
) ();
  logic         o_fifo_rd;
  logic         i_fifo_empty_n;
  logic [B-1:0] i_fifo_data;
  logic         o_valid;
  logic         i_ready;
  logic [B-1:0] o_data;

  modport master (
    output o_fifo_rd, o_valid, o_data,
    input  i_fifo_empty_n, i_fifo_data, i_ready
  );

  modport slave (
    input  o_fifo_rd, o_valid, o_data,
    output i_fifo_empty_n, i_fifo_data, i_ready
  );
endinterface

// File: rtl/fifo_reader.sv
// Purpose: drains a registered-output FIFO into a valid/ready stream through a 4-entry skid buffer.
// Latency: a word is presented RD_LAT rising edges after the edge that samples its o_fifo_rd.
// Backpressure: reads are credit-limited (buffered + in-flight <= 4), so i_ready never gates o_fifo_rd.
// Ports: i_clk, i_rst_n (async active-low), i_en (allow new reads), o_idle (nothing buffered or in flight),
//        bus (fifo_reader_if.master): FIFO rd/empty_n/data and stream valid/ready/data.
module fifo_reader #(
  parameter int B      = 8,
  parameter int RD_LAT = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  output logic          o_idle,
  fifo_reader_if.master bus
);

  logic [B-1:0]      mem [4];
  logic [1:0]        wptr;
  logic [1:0]        rptr;
  logic [2:0]        occ;
  logic [RD_LAT-1:0] trk;
  logic [2:0]        inflight;
  logic              credit_ok;
  logic              rd;
  logic              cap;
  logic              pop;

  // Number of reads issued whose data has not yet returned.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + {2'b00, trk[i]};
    end
  end

  // Every issued read owns a buffer slot until it is popped, so a returning word can never overflow.
  // Widened to 4 bits so a broken invariant cannot wrap back into the "room left" range.
  assign credit_ok = ({1'b0, occ} + {1'b0, inflight}) < 4'd4;
  assign rd        = i_en & bus.i_fifo_empty_n & credit_ok;
  assign cap       = trk[RD_LAT-1];
  assign pop       = (occ != 3'd0) & bus.i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      trk  <= '0;
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      for (int i = 0; i < 4; i++) begin
        mem[i] <= '0;
      end
    end else begin
      trk <= (trk << 1) | RD_LAT'(rd);
      if (cap) begin
        mem[wptr] <= bus.i_fifo_data;
        wptr      <= wptr + 2'd1;
      end
      if (pop) begin
        rptr <= rptr + 2'd1;
      end
      case ({cap, pop})
        2'b10:   occ <= occ + 3'd1;
        2'b01:   occ <= occ - 3'd1;
        default: ;
      endcase
    end
  end

  assign bus.o_fifo_rd = rd;
  assign bus.o_valid   = (occ != 3'd0);
  assign bus.o_data    = (occ != 3'd0) ? mem[rptr] : '0;
  assign o_idle        = (occ == 3'd0) && (inflight == 3'd0);

endmodule

// File: tb/tb_fifo_reader.sv
// Purpose: bench for fifo_reader with RD_LAT=2 (dut2) and RD_LAT=3 (dut3) against a behavioural FIFO model.
// Expected words are queued by the stimulus; negedge monitors pop and compare whenever valid & ready.
// Stream hold, credit invariant and reads-on-empty are checked every cycle.
module tb_fifo_reader;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  logic rst2_n, rst3_n, en2, en3, rdy2, rdy3, idle2, idle3;

  fifo_reader_if #(.B(8)) if2 ();
  fifo_reader_if #(.B(8)) if3 ();

  fifo_reader #(.B(8), .RD_LAT(2)) dut2 (
    .i_clk   (i_clk),
    .i_rst_n (rst2_n),
    .i_en    (en2),
    .o_idle  (idle2),
    .bus     (if2.master)
  );

  fifo_reader #(.B(8), .RD_LAT(3)) dut3 (
    .i_clk   (i_clk),
    .i_rst_n (rst3_n),
    .i_en    (en3),
    .o_idle  (idle3),
    .bus     (if3.master)
  );

  // ---------------- FIFO models: registered empty flag, RD_LAT-stage data return ----------------
  logic [7:0] q2[$];
  logic [7:0] q3[$];
  logic [7:0] dp2 [2] = '{8'hEE, 8'hEE};
  logic [7:0] dp3 [3] = '{8'hEE, 8'hEE, 8'hEE};
  logic       emp2_n = 1'b0;
  logic       emp3_n = 1'b0;
  int         rd_cnt2 = 0;
  int         rd_cnt3 = 0;

  assign if2.i_fifo_empty_n = emp2_n;
  assign if2.i_fifo_data    = dp2[1];
  assign if2.i_ready        = rdy2;
  assign if3.i_fifo_empty_n = emp3_n;
  assign if3.i_fifo_data    = dp3[2];
  assign if3.i_ready        = rdy3;

  always @(posedge i_clk) begin
    logic [7:0] w;
    w = 8'hEE;
    if (if2.o_fifo_rd) begin
      tests++;
      if (q2.size() == 0) begin
        fails++;
        $display("FAIL rd_on_empty2: read issued with 0 words in FIFO, required none");
      end else begin
        w = q2.pop_front();
      end
      rd_cnt2++;
    end
    dp2[1] <= dp2[0];
    dp2[0] <= w;
    emp2_n <= (q2.size() != 0);
  end

  always @(posedge i_clk) begin
    logic [7:0] w;
    w = 8'hEE;
    if (if3.o_fifo_rd) begin
      tests++;
      if (q3.size() == 0) begin
        fails++;
        $display("FAIL rd_on_empty3: read issued with 0 words in FIFO, required none");
      end else begin
        w = q3.pop_front();
      end
      rd_cnt3++;
    end
    dp3[2] <= dp3[1];
    dp3[1] <= dp3[0];
    dp3[0] <= w;
    emp3_n <= (q3.size() != 0);
  end

  // ---------------- scoreboards / monitors ----------------
  logic [7:0] exp2[$];
  logic [7:0] exp3[$];
  logic       hold2 = 1'b0;
  logic       hold3 = 1'b0;
  logic [7:0] hold_dat2, hold_dat3;
  int first_rd2 = -1, last_rd2 = -1, first_val2 = -1, last_val2 = -1;

  always @(negedge i_clk) begin
    logic [7:0] e;
    if (hold2) begin
      tests++;
      if (!(if2.o_valid && if2.o_data == hold_dat2)) begin
        fails++;
        $display("FAIL hold2: valid=%0b data=0x%0h, required valid=1 data=0x%0h", if2.o_valid, if2.o_data, hold_dat2);
      end
    end
    hold2     = if2.o_valid && !rdy2;
    hold_dat2 = if2.o_data;
    if (if2.o_fifo_rd) begin
      if (first_rd2 < 0) first_rd2 = cyc;
      last_rd2 = cyc;
    end
    if (if2.o_valid) begin
      if (first_val2 < 0) first_val2 = cyc;
      last_val2 = cyc;
    end
    if (if2.o_valid && rdy2) begin
      tests++;
      if (exp2.size() == 0) begin
        fails++;
        $display("FAIL data2: unexpected word 0x%0h, required no word", if2.o_data);
      end else begin
        e = exp2.pop_front();
        if (if2.o_data !== e) begin
          fails++;
          $display("FAIL data2: got 0x%0h, required 0x%0h", if2.o_data, e);
        end
      end
    end
    tests++;
    if (({1'b0, dut2.occ} + {1'b0, dut2.inflight}) > 4'd4) begin
      fails++;
      $display("FAIL credit2: occ+inflight=%0d, required <= 4", dut2.occ + dut2.inflight);
    end
  end

  always @(negedge i_clk) begin
    logic [7:0] e;
    if (hold3) begin
      tests++;
      if (!(if3.o_valid && if3.o_data == hold_dat3)) begin
        fails++;
        $display("FAIL hold3: valid=%0b data=0x%0h, required valid=1 data=0x%0h", if3.o_valid, if3.o_data, hold_dat3);
      end
    end
    hold3     = if3.o_valid && !rdy3;
    hold_dat3 = if3.o_data;
    if (if3.o_valid && rdy3) begin
      tests++;
      if (exp3.size() == 0) begin
        fails++;
        $display("FAIL data3: unexpected word 0x%0h, required no word", if3.o_data);
      end else begin
        e = exp3.pop_front();
        if (if3.o_data !== e) begin
          fails++;
          $display("FAIL data3: got 0x%0h, required 0x%0h", if3.o_data, e);
        end
      end
    end
    tests++;
    if (({1'b0, dut3.occ} + {1'b0, dut3.inflight}) > 4'd4) begin
      fails++;
      $display("FAIL credit3: occ+inflight=%0d, required <= 4", dut3.occ + dut3.inflight);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  initial begin
    #200000;
    fails++;
    $display("FAIL global_timeout: bench did not finish, required finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int rc0;
    int found;
    rst2_n = 1'b0; rst3_n = 1'b0;
    en2 = 1'b0; en3 = 1'b0; rdy2 = 1'b0; rdy3 = 1'b0;
    #12;
    check("rst_rd2",    if2.o_fifo_rd, 0);
    check("rst_valid2", if2.o_valid,   0);
    check("rst_data2",  if2.o_data,    0);
    check("rst_idle2",  idle2,         1);
    check("rst_valid3", if3.o_valid,   0);
    check("rst_idle3",  idle3,         1);
    @(posedge i_clk); #1;
    rst2_n = 1'b1; rst3_n = 1'b1;
    tick(2);

    // Stream with i_ready high: 8 back-to-back reads and 8 back-to-back words.
    for (int i = 1; i <= 8; i++) begin q2.push_back(8'(i)); exp2.push_back(8'(i)); end
    first_rd2 = -1; last_rd2 = -1; first_val2 = -1; last_val2 = -1;
    rc0 = rd_cnt2;
    rdy2 = 1'b1; en2 = 1'b1;
    for (int k = 0; k < 100; k++) begin tick(1); if (idle2 && exp2.size() == 0 && rd_cnt2 - rc0 >= 8) break; end
    check("stream_reads",   rd_cnt2 - rc0, 8);
    check("stream_rd_run",  last_rd2 - first_rd2, 7);
    // rd is sampled at the end of its cycle, the word is captured RD_LAT edges later and shows in that cycle.
    check("stream_latency", first_val2 - first_rd2, 3);
    check("stream_val_run", last_val2 - first_val2, 7);
    check("stream_idle",    idle2, 1);
    check("stream_drained", exp2.size(), 0);
    en2 = 1'b0;
    tick(2);

    // Backpressure: only 4 reads fit, head word held.
    rdy2 = 1'b0;
    for (int i = 0; i < 8; i++) begin q2.push_back(8'h10 + 8'(i)); exp2.push_back(8'h10 + 8'(i)); end
    rc0 = rd_cnt2;
    en2 = 1'b1;
    tick(12);
    check("bp_reads", rd_cnt2 - rc0, 4);
    check("bp_occ",   dut2.occ, 4);
    check("bp_valid", if2.o_valid, 1);
    check("bp_head",  if2.o_data, 8'h10);
    rdy2 = 1'b1;
    for (int k = 0; k < 100; k++) begin tick(1); if (idle2 && exp2.size() == 0) break; end
    check("bp_drained", exp2.size(), 0);
    check("bp_idle",    idle2, 1);
    en2 = 1'b0;
    tick(2);

    // Empty FIFO with enable high.
    rc0 = rd_cnt2;
    en2 = 1'b1;
    tick(6);
    check("empty_reads", rd_cnt2 - rc0, 0);
    check("empty_valid", if2.o_valid, 0);
    check("empty_idle",  idle2, 1);
    en2 = 1'b0;

    // Enable drop the cycle after the 2nd read.
    for (int i = 0; i < 6; i++) q2.push_back(8'h20 + 8'(i));
    exp2.push_back(8'h20); exp2.push_back(8'h21);
    rc0 = rd_cnt2;
    en2 = 1'b1;
    for (int k = 0; k < 20; k++) begin tick(1); if (rd_cnt2 - rc0 >= 2) break; end
    en2 = 1'b0;
    for (int k = 0; k < 50; k++) begin tick(1); if (idle2 && exp2.size() == 0) break; end
    check("endrop_reads",   rd_cnt2 - rc0, 2);
    check("endrop_drained", exp2.size(), 0);
    check("endrop_idle",    idle2, 1);
    q2.delete();
    tick(3);

    // Reset with 2 buffered and 2 in flight; stale returning data must not be captured.
    rdy2 = 1'b0;
    for (int i = 0; i < 8; i++) q2.push_back(8'h30 + 8'(i));
    en2 = 1'b1;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (dut2.occ == 3'd2 && dut2.inflight == 3'd2) begin found = 1; break; end
    end
    check("rst_mid_reached", found, 1);
    rst2_n = 1'b0; en2 = 1'b0;
    #1;
    check("rst_mid_rd",    if2.o_fifo_rd, 0);
    check("rst_mid_valid", if2.o_valid,   0);
    check("rst_mid_data",  if2.o_data,    0);
    check("rst_mid_idle",  idle2,         1);
    q2.delete();
    hold2 = 1'b0;
    #1;
    rst2_n = 1'b1;
    rdy2 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("rst_stale_valid", if2.o_valid, 0);
    end
    check("rst_stale_idle", idle2, 1);

    // RD_LAT=3, alternating ready, 12 words.
    for (int i = 0; i < 12; i++) begin q3.push_back(8'h40 + 8'(i)); exp3.push_back(8'h40 + 8'(i)); end
    rc0 = rd_cnt3;
    rdy3 = 1'b0;
    en3 = 1'b1;
    for (int k = 0; k < 200; k++) begin
      rdy3 = ~rdy3;
      tick(1);
      if (idle3 && exp3.size() == 0 && rd_cnt3 - rc0 >= 12) break;
    end
    check("alt_reads",   rd_cnt3 - rc0, 12);
    check("alt_drained", exp3.size(), 0);
    check("alt_idle",    idle3, 1);
    en3 = 1'b0;
    tick(2);

    check("final_exp2_empty", exp2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
